// File: rtl/clk_en_pkg.sv
// Shared constants for the clock-enable generator: system clock rate,
// named terminal counts for the stopwatch enables, and the default width.
package clk_en_pkg;

    localparam int unsigned CLK_HZ        = 100_000_000;
    localparam int unsigned CNT_W_DEFAULT = 27;

    // Terminal count D gives a period of D+1 system clocks
    localparam int unsigned DIV_1HZ   = 99_999_999;
    localparam int unsigned DIV_2HZ   = 49_999_999;
    localparam int unsigned DIV_BLINK = 33_333_333;
    localparam int unsigned DIV_1KHZ  = 99_999;

endpackage

// File: rtl/clk_en_channel.sv
// One clock-enable channel: programmable terminal count, tick pulse and
// optional square-wave level (present when CLK_EN_GEN_LEVEL_EN is defined).
module clk_en_channel
    import clk_en_pkg::*;
#(
    parameter int unsigned      CNT_W   = CNT_W_DEFAULT,
    parameter logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_1HZ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             we,
    input  logic [CNT_W-1:0] wdiv,
    output logic             tick,
    output logic             level
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div;
    logic             wrap;

    assign wrap = (cnt == div);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            div  <= DIV_RST;
            tick <= 1'b0;
        end else if (clr) begin
            // A write coinciding with the clear still lands in div
            cnt  <= '0;
            tick <= 1'b0;
            if (we) div <= wdiv;
        end else if (we) begin
            div  <= wdiv;
            cnt  <= '0;
            tick <= 1'b0;
        end else if (en) begin
            if (wrap) begin
                cnt  <= '0;
                tick <= 1'b1;
            end else begin
                cnt  <= cnt + 1'b1;
                tick <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

`ifdef CLK_EN_GEN_LEVEL_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level <= 1'b0;
        end else if (clr) begin
            level <= 1'b0;
        end else if (!we && en && wrap) begin
            level <= ~level;
        end
    end
`else
    assign level = 1'b0;
`endif

endmodule

// File: rtl/clk_enable_gen.sv
// Multi-channel clock-enable generator; level outputs exist only when
// CLK_EN_GEN_LEVEL_EN is defined, otherwise they are tied low.
module clk_enable_gen
    import clk_en_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = CNT_W_DEFAULT,
    parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT = {
        CNT_W'(DIV_1KHZ), CNT_W'(DIV_BLINK), CNT_W'(DIV_2HZ), CNT_W'(DIV_1HZ)
    },
    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en,
    input  logic              sync_clr,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] level
);

    logic [NUM_CH-1:0] ch_we;

    // Out-of-range channel indices match no strobe and are dropped
    always_comb begin
        ch_we = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            ch_we[i] = cfg_we && (cfg_ch == CH_W'(i));
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clk_en_channel #(
            .CNT_W   (CNT_W),
            .DIV_RST (DIV_INIT[g*CNT_W +: CNT_W])
        ) u_ch (
            .clk   (clk),
            .rst   (rst),
            .en    (en[g]),
            .clr   (sync_clr),
            .we    (ch_we[g]),
            .wdiv  (cfg_div),
            .tick  (tick[g]),
            .level (level[g])
        );
    end

endmodule

// File: tb/tb_clk_enable_gen.sv
// Randomized bench for clk_enable_gen: two instances (4 and 3 channels) share
// stimulus and are checked every cycle against an elapsed-cycle reference model.
module tb_clk_enable_gen;

    localparam int unsigned CNT_W = 8;
    localparam int unsigned NTOT  = 7;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       en;
    logic             sync_clr;
    logic             cfg_we;
    logic [1:0]       cfg_ch;
    logic [CNT_W-1:0] cfg_div;
    logic [3:0]       tick_a, level_a;
    logic [2:0]       tick_b, level_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    clk_enable_gen #(
        .NUM_CH   (4),
        .CNT_W    (CNT_W),
        .DIV_INIT ({8'd0, 8'd1, 8'd2, 8'd3})
    ) dut_a (
        .clk (clk), .rst (rst), .en (en), .sync_clr (sync_clr),
        .cfg_we (cfg_we), .cfg_ch (cfg_ch), .cfg_div (cfg_div),
        .tick (tick_a), .level (level_a)
    );

    // Three channels: cfg_ch == 3 is out of range here
    clk_enable_gen #(
        .NUM_CH   (3),
        .CNT_W    (CNT_W),
        .DIV_INIT ({8'd2, 8'd0, 8'd3})
    ) dut_b (
        .clk (clk), .rst (rst), .en (en[2:0]), .sync_clr (sync_clr),
        .cfg_we (cfg_we), .cfg_ch (cfg_ch), .cfg_div (cfg_div),
        .tick (tick_b), .level (level_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: slots 0..3 are dut_a channels, 4..6 are dut_b channels.
    // m_n counts enabled cycles since the period began; a tick fires when it reaches D+1.
    int unsigned m_div [NTOT];
    int unsigned m_n   [NTOT];
    bit          m_tk  [NTOT];
    bit          m_lv  [NTOT];

    function automatic int unsigned init_div(input int unsigned k);
        int unsigned tbl [NTOT] = '{3, 2, 1, 0, 3, 0, 2};
        return tbl[k];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NTOT; k++) begin
                m_div[k] <= init_div(k);
                m_n[k]   <= 0;
                m_tk[k]  <= 1'b0;
                m_lv[k]  <= 1'b0;
            end
        end else begin
            for (int k = 0; k < NTOT; k++) begin
                automatic int unsigned ch  = (k < 4) ? k : k - 4;
                automatic bit          hit = cfg_we && (int'(cfg_ch) == ch);
                automatic int unsigned n1  = m_n[k] + 1;
                if (sync_clr) begin
                    m_n[k]  <= 0;
                    m_tk[k] <= 1'b0;
                    m_lv[k] <= 1'b0;
                    if (hit) m_div[k] <= cfg_div;
                end else if (hit) begin
                    m_div[k] <= cfg_div;
                    m_n[k]   <= 0;
                    m_tk[k]  <= 1'b0;
                end else if (en[ch]) begin
                    if (n1 == m_div[k] + 1) begin
                        m_n[k]  <= 0;
                        m_tk[k] <= 1'b1;
                        m_lv[k] <= ~m_lv[k];
                    end else begin
                        m_n[k]  <= n1;
                        m_tk[k] <= 1'b0;
                    end
                end else begin
                    m_tk[k] <= 1'b0;
                end
            end
        end
    end

    function automatic logic [6:0] exp_tick();
        logic [6:0] v;
        for (int k = 0; k < NTOT; k++) v[k] = m_tk[k];
        return v;
    endfunction

    function automatic logic [6:0] exp_level();
        logic [6:0] v;
        v = '0;
`ifdef CLK_EN_GEN_LEVEL_EN
        for (int k = 0; k < NTOT; k++) v[k] = m_lv[k];
`endif
        return v;
    endfunction

    int cyc;
    int first0, first1, first3;

    task automatic step();
        logic [6:0] et, el;
        @(negedge clk);
        cyc++;
        et = exp_tick();
        el = exp_level();
        check("tick_a",  32'(tick_a),  32'(et[3:0]));
        check("tick_b",  32'(tick_b),  32'(et[6:4]));
        check("level_a", 32'(level_a), 32'(el[3:0]));
        check("level_b", 32'(level_b), 32'(el[6:4]));
        if (tick_a[0] && first0 < 0) first0 = cyc;
        if (tick_a[1] && first1 < 0) first1 = cyc;
        if (tick_a[3] && first3 < 0) first3 = cyc;
    endtask

    task automatic idle_inputs();
        sync_clr = 1'b0;
        cfg_we   = 1'b0;
        cfg_ch   = '0;
        cfg_div  = '0;
    endtask

    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        check("rst_tick",  32'({tick_a, tick_b}),   32'd0);
        check("rst_level", 32'({level_a, level_b}), 32'd0);
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        en  = '0;
        idle_inputs();
        cyc = 0; first0 = -1; first1 = -1; first3 = -1;
        repeat (3) step();
        rst = 1'b0;
        en  = 4'hF;
        cyc = 0; first0 = -1; first1 = -1; first3 = -1;

        // Free-running: ch0 every 4, ch1 every 3, ch3 constantly
        repeat (24) step();
        check("first_tick_ch0", 32'(first0), 32'd4);
        check("first_tick_ch1", 32'(first1), 32'd3);
        check("first_tick_ch3", 32'(first3), 32'd1);

        // Pause ch0 mid-count for 5 cycles
        step();
        en[0] = 1'b0;
        repeat (5) step();
        en[0] = 1'b1;
        repeat (12) step();

        // Reprogram ch1 to D=5 while running
        cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd5;
        step();
        idle_inputs();
        repeat (14) step();

        // Phase realign everything
        step();
        sync_clr = 1'b1;
        step();
        sync_clr = 1'b0;
        repeat (12) step();

        // cfg_ch = 3: writes dut_a ch3, out of range for dut_b
        cfg_we = 1'b1; cfg_ch = 2'd3; cfg_div = 8'd2;
        step();
        idle_inputs();
        repeat (10) step();

        // Write coincident with sync_clr
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd1; sync_clr = 1'b1;
        step();
        idle_inputs();
        repeat (10) step();

        // Reset mid-period discards the earlier writes
        step();
        async_reset();
        repeat (12) step();

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            en       = ($urandom_range(0, 9) < 8) ? 4'hF : 4'($urandom);
            sync_clr = ($urandom_range(0, 49) == 0);
            cfg_we   = ($urandom_range(0, 19) == 0);
            cfg_ch   = 2'($urandom);
            cfg_div  = CNT_W'($urandom_range(0, 7));
            if ($urandom_range(0, 299) == 0) begin
                idle_inputs();
                async_reset();
            end else begin
                step();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_enable_gen.md
# clk_enable_gen

Parametrised multi-channel clock-enable generator: the single fixed blink divider generalised to NUM_CH independent channels, each producing a one-cycle tick pulse and a 50 %-duty level output from the system clock. Divisors are runtime-programmable, channels can be individually paused, and all channels can be phase-realigned together. It sits beside the stopwatch counter and display logic, supplying the 1 Hz count, 2 Hz adjust, 1.5 Hz blink and 1 kHz digit-refresh enables.

## Interface
- NUM_CH, 4, number of channels
- CNT_W, 27, counter and divisor width in bits
- DIV_INIT, {27'd99_999, 27'd33_333_333, 27'd49_999_999, 27'd99_999_999}, packed NUM_CH*CNT_W reset divisors; channel i occupies bits [i*CNT_W +: CNT_W]
- clk  in  1  system clock (100 MHz)
- rst  in  1  asynchronous, active-high reset
- en  in  NUM_CH  per-channel count enable
- sync_clr  in  1  synchronous clear of all channels (phase align)
- cfg_we  in  1  divisor write strobe
- cfg_ch  in  $clog2(NUM_CH)  channel index for the write
- cfg_div  in  CNT_W  new terminal count D
- tick  out  NUM_CH  one-cycle pulse per channel period
- level  out  NUM_CH  square wave, toggles on every tick

## Operation
- Per channel: registers cnt, div, tick, level. Period = div+1 cycles; level period = 2*(div+1).
- Priority per edge, highest first: rst (async), sync_clr, cfg write to this channel, counting.
- rst: cnt=0, div=DIV_INIT slice, tick=0, level=0.
- sync_clr: every channel cnt=0, tick=0, level=0; div unchanged.
- cfg_we with cfg_ch<NUM_CH: div[cfg_ch]<=cfg_div, cnt<=0, tick<=0, level held. cfg_ch>=NUM_CH: write ignored.
- Counting, en[i]=1: if cnt==div then cnt<=0, tick<=1, level<=~level; else cnt<=cnt+1, tick<=0.
- en[i]=0: cnt and level hold, tick<=0.
- div=0: tick held high continuously while enabled; level toggles every cycle.
- cnt never exceeds div; no overflow possible, since cnt wraps at div<=2^CNT_W-1.

## Timing
- All outputs registered; no combinational path from inputs to outputs.
- With en high from reset release, first tick is high during cycle D+1 (after edge D+1); thereafter every D+1 cycles.
- Deasserting en for N cycles delays the next tick by exactly N cycles.
- New divisor takes effect immediately: first tick D'+1 cycles after the write edge.
- sync_clr and cfg_we in the same cycle: sync_clr wins for every channel, and the write is still applied to div.
- A tick coincident with sync_clr or a write to its channel is suppressed.

## Configuration
- CLK_EN_GEN_LEVEL_EN defined: level outputs and their toggle registers are present as described.
- Not defined: level is tied to 0 and the toggle flops are removed; tick behaviour is unchanged.

## Structure
- Package clk_en_pkg: CLK_HZ=100_000_000, named divisor constants (DIV_1HZ=99_999_999, DIV_2HZ=49_999_999, DIV_BLINK=33_333_333, DIV_1KHZ=99_999), and the default CNT_W.
- Sub-module clk_en_channel holds one cnt/div/tick/level slice. The top instantiates it NUM_CH times in a generate loop and decodes cfg_ch into per-channel write strobes.

## Test plan
- Bench DIV_INIT={3,2,1,0}, en=4'hF after reset: ch0 ticks every 4 cycles, ch1 every 3, ch2 every 2, ch3 tick constantly high; level periods 8/6/4/2.
- ch0 D=3, drop en[0] for 5 cycles mid-count: next tick arrives exactly 5 cycles late, and level does not toggle while paused.
- Write cfg_ch=1, cfg_div=5 while ch1 is running: ch1 cnt resets and the next tick follows 6 cycles after the write; other channels are undisturbed.
- Pulse sync_clr with channels at differing phases: all ticks and levels go to 0, and channels with equal D tick simultaneously thereafter.
- Assert rst mid-period, asynchronously between edges: outputs go to 0 immediately, div returns to DIV_INIT, and a prior cfg write is discarded.
- cfg_ch=NUM_CH (out of range) write: no divisor changes; cfg_we together with sync_clr: all cleared and new div used from the next period.
